// File: rtl/hor_sync_gen_pkg.sv
// Shared VGA timing constants and horizontal state encoding.
package hor_sync_gen_pkg;

    localparam int H_SYNC      = 384;
    localparam int H_BP        = 192;
    localparam int H_DISP      = 2560;
    localparam int H_FP        = 64;
    localparam int CLK_PER_PIX = 4;
    localparam int H_TOTAL     = H_SYNC + H_BP + H_DISP + H_FP;
    localparam int DISP_START  = H_SYNC + H_BP;
    localparam int DISP_END    = H_SYNC + H_BP + H_DISP - 1;

    localparam int H_CNT_W     = 12;
    localparam int PIX_COL_W   = 10;

    typedef enum logic [1:0] {
        SYNC        = 2'd0,
        BACK_PORCH  = 2'd1,
        DISPLAY     = 2'd2,
        FRONT_PORCH = 2'd3
    } h_state_t;

endpackage

// File: rtl/wrap_counter.sv
// Free-running modulo counter with terminal count and look-ahead next value.
module wrap_counter #(
    parameter int WIDTH   = 12,
    parameter int MODULUS = 3200
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_next,
    output logic             tc
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
        $error("wrap_counter: MODULUS does not fit WIDTH");
    end

    assign tc         = (count == LAST);
    assign count_next = tc ? '0 : count + 1'b1;

    // Count register; wraps to zero after the terminal value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/hor_sync_gen.sv
// Horizontal VGA timing: position counter, hsync, display window and pixel strobes.
// All flags are registered from the decoded next count so they line up with H_count.
//
// state       | meaning
// SYNC        | hsync low, H_count 0 .. H_SYNC-1
// BACK_PORCH  | blanking after sync
// DISPLAY     | active video, pixel strobes running
// FRONT_PORCH | blanking before the next sync
module hor_sync_gen
    import hor_sync_gen_pkg::*;
#(
    parameter int H_SYNC      = hor_sync_gen_pkg::H_SYNC,
    parameter int H_BP        = hor_sync_gen_pkg::H_BP,
    parameter int H_DISP      = hor_sync_gen_pkg::H_DISP,
    parameter int H_FP        = hor_sync_gen_pkg::H_FP,
    parameter int CLK_PER_PIX = hor_sync_gen_pkg::CLK_PER_PIX
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic [11:0] H_count,
    output logic       hsync,
    output logic       h_display,
    output logic [9:0] pix_col,
    output logic       pix_tick,
    output logic       line_end
);

    localparam int TOTAL = H_SYNC + H_BP + H_DISP + H_FP;
    localparam int SUB_W = $clog2(CLK_PER_PIX);

    localparam logic [11:0] SYNC_END_C  = 12'(H_SYNC);
    localparam logic [11:0] D_START_C   = 12'(H_SYNC + H_BP);
    localparam logic [11:0] D_END_P1_C  = 12'(H_SYNC + H_BP + H_DISP);
    localparam logic [11:0] LAST_C      = 12'(TOTAL - 1);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(CLK_PER_PIX - 1);

    if (TOTAL > 4095) begin : g_bad_total
        $error("hor_sync_gen: H_TOTAL exceeds 4095");
    end
    if ((H_DISP % CLK_PER_PIX) != 0) begin : g_bad_disp
        $error("hor_sync_gen: H_DISP not a multiple of CLK_PER_PIX");
    end
    // The pixel sub-counter relies on natural binary wrap.
    if (CLK_PER_PIX < 2 || (1 << SUB_W) != CLK_PER_PIX) begin : g_bad_cpp
        $error("hor_sync_gen: CLK_PER_PIX must be a power of two >= 2");
    end

    h_state_t         state;
    h_state_t         state_nxt;
    logic [11:0]      h_cnt_nxt;
    logic             h_tc;
    logic [SUB_W-1:0] sub_cnt;
    logic [SUB_W-1:0] sub_nxt;
    logic [9:0]       pix_col_nxt;

    wrap_counter #(
        .WIDTH   (12),
        .MODULUS (TOTAL)
    ) u_h_cnt (
        .clk        (clk),
        .reset_n    (reset_n),
        .count      (H_count),
        .count_next (h_cnt_nxt),
        .tc         (h_tc)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= SYNC;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state from the count value about to be loaded.
    always_comb begin
        state_nxt = state;
        case (state)
            SYNC:        if (h_cnt_nxt == SYNC_END_C) state_nxt = BACK_PORCH;
            BACK_PORCH:  if (h_cnt_nxt == D_START_C)  state_nxt = DISPLAY;
            DISPLAY:     if (h_cnt_nxt == D_END_P1_C) state_nxt = FRONT_PORCH;
            FRONT_PORCH: if (h_tc)                    state_nxt = SYNC;
            default:     state_nxt = SYNC;
        endcase
    end

    // Pixel phase and column; both restart on entry to the display window.
    always_comb begin
        sub_nxt     = '0;
        pix_col_nxt = '0;
        if (state_nxt == DISPLAY && state == DISPLAY) begin
            sub_nxt     = sub_cnt + 1'b1;
            pix_col_nxt = pix_tick ? pix_col + 1'b1 : pix_col;
        end
    end

    // Registered outputs, aligned with the count value they describe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sub_cnt   <= '0;
            hsync     <= 1'b0;
            h_display <= 1'b0;
            pix_col   <= '0;
            pix_tick  <= 1'b0;
            line_end  <= 1'b0;
        end else begin
            sub_cnt   <= sub_nxt;
            hsync     <= (state_nxt != SYNC);
            h_display <= (state_nxt == DISPLAY);
            pix_col   <= pix_col_nxt;
            pix_tick  <= (state_nxt == DISPLAY) && (sub_nxt == SUB_LAST);
            line_end  <= (h_cnt_nxt == LAST_C);
        end
    end

endmodule
